spart_wr_sink: RTL and testbench
================================

# spart_wr_sink

Memory-mapped write sink on the SPART side of the CPU store port: it consumes `spart_wrt_en` / `spart_wrt_add` / `spart_wrt_data` write strobes issued from the CPU MEM stage. Writes inside the SPART window are queued in a small FIFO. Each entry is serialized onto an 8N1 UART TX line. The CPU store port has no back-pressure, so a write that arrives with the FIFO full is dropped and counted.

## Interface
- `FIFO_DEPTH`, 8, number of queue entries; power of two, ≥2.
- `CLK_DIV`, 434, clk cycles per UART bit; ≥2.
- `WIN_BASE`, 32'hFFFF_FFF0, base of the 16-word SPART window; `WIN_BASE[3:0]` = 0.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `spart_wrt_en`  in  1  one-cycle store strobe from the CPU MEM stage.
- `spart_wrt_add`  in  32  store word address.
- `spart_wrt_data`  in  32  store data.
- `txd`  out  1  UART serial output; idles high.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_full`  out  1  FIFO occupancy equals `FIFO_DEPTH`.
- `ovf_cnt`  out  8  count of dropped writes; saturates at 255.

## Operation
- A write is a hit when `spart_wrt_en` = 1 and `spart_wrt_add[31:4]` = `WIN_BASE[31:4]`. Non-hits are ignored.
- Offset 0x0 (BYTE) pushes an entry `{data[7:0], len=1}`.
- Offset 0x1 (WORD) pushes `{data[31:0], len=4}`. Bytes go out LSB first.
- Offset 0x2 (CLR) clears `ovf_cnt` to 0. It does not touch the FIFO.
- All other offsets are ignored.
- Push acceptance: a hit is accepted if not full, or if a pop occurs in the same cycle. Otherwise it is dropped and `ovf_cnt` increments, saturating.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when the FIFO is non-empty, pop the head into a shift register with `bytes_left` = len, then go to START.
- START: `txd` = 0 for one bit time, then DATA with bit index 0.
- DATA: `txd` = current byte bit, LSB first. After bit 7, go to PAR if parity is built in, otherwise STOP.
- PAR: `txd` = XOR of the data byte (even parity) for one bit time, then STOP.
- STOP: `txd` = 1 for one bit time.
- At the end of STOP: if `bytes_left` > 1, decrement it, shift the next byte in, and go to START without an idle gap. Otherwise go to IDLE.
- Counters:
  - Bit-time counter counts 0..`CLK_DIV`-1.
  - FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally.
  - Occupancy counter is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `fifo_full`=0, `ovf_cnt`=0. FSM in IDLE, FIFO empty.
- Push latency:
  - A hit sampled at edge N updates occupancy at N.
  - The FSM pops at edge N+1 if it was IDLE.
  - `txd` falls from edge N+1 (registered output).
- Each bit lasts exactly `CLK_DIV` cycles.
  - BYTE frame: 10·`CLK_DIV` cycles, or 11·`CLK_DIV` with parity.
  - WORD frame: 4× the BYTE frame, back to back.
- The entry just popped is retired from the FIFO on the pop edge, so a full FIFO frees a slot immediately on pop.
- Simultaneous CLR and overflow in the same cycle cannot occur (one write per cycle). A CLR with a non-hit drop pending is not a case.
- Reset asserted mid-frame: `txd` returns to 1 asynchronously, the FIFO is emptied, and the partial frame is abandoned.
- Back-to-back hits on consecutive cycles are all accepted up to capacity.

## Configuration
- `SPART_PARITY_EN` defined: the PAR state exists and frames are 11 bits with even parity.
- Not defined: the PAR state and its logic are removed and frames are 10 bits (8N1).

## Structure
- Shared package `spart_pkg`:
  - TX FSM state enum.
  - Offset constants `SPART_OFF_BYTE`=4'h0, `SPART_OFF_WORD`=4'h1, `SPART_OFF_CLR`=4'h2.
  - Length encoding.
- One sub-module, `spart_tx_fifo`: a synchronous FIFO (push/pop/full/empty/count) with a 34-bit entry of 32-bit data plus a 2-bit length code.
- Address decode, overflow counter and TX FSM live in the top level.

## Test plan
Benches use `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- BYTE write 0x55 to `WIN_BASE`+0 → `txd` pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, starting one edge after the write; `tx_busy` drops after 40 cycles.
- WORD write 0xA1B2C3D4 to `WIN_BASE`+1 → bytes D4, C3, B2, A1 in that order with no idle between frames; 160 cycles total.
- Write to `WIN_BASE`+0x10 and to offset 0x5 → `txd` stays 1, FIFO unchanged, `ovf_cnt` unchanged.
- Six BYTE writes on consecutive cycles with the FSM idle → the first pops at once and four are queued; the sixth is dropped; `ovf_cnt`=1; `fifo_full`=1. Then a CLR write sets `ovf_cnt`=0 while the FIFO keeps draining.
- Assert `rst` mid-WORD frame → `txd`=1 immediately and FIFO empty. After release, a BYTE 0x0F transmits cleanly.
- With `SPART_PARITY_EN`: BYTE 0x07 → parity bit 1 and an 11-bit frame. BYTE 0x03 → parity bit 0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART write sink: TX FSM states,
// window offsets and the FIFO entry layout.
package spart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } tx_state_t;

   localparam logic [3:0] SPART_OFF_BYTE = 4'h0;
   localparam logic [3:0] SPART_OFF_WORD = 4'h1;
   localparam logic [3:0] SPART_OFF_CLR  = 4'h2;

   // Length code stores (byte count - 1).
   localparam logic [1:0] SPART_LEN_BYTE = 2'd0;
   localparam logic [1:0] SPART_LEN_WORD = 2'd3;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  len;
   } spart_entry_t;

endpackage

// File: rtl/spart_tx_fifo.sv
// Synchronous FIFO of SPART TX entries (32-bit data + 2-bit length code).
// Head entry is presented combinationally on dout.
module spart_tx_fifo
   import spart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  spart_entry_t din,
   output spart_entry_t dout,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   localparam int CW = AW + 1;

   spart_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/spart_wr_sink.sv
// SPART store sink: decodes CPU writes into the SPART window, queues them and
// serializes each entry onto a UART TX line. Define SPART_PARITY_EN for 8E1 frames.
module spart_wr_sink
   import spart_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter int          CLK_DIV    = 434,
   parameter logic [31:0] WIN_BASE   = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spart_wrt_en,
   input  logic [31:0] spart_wrt_add,
   input  logic [31:0] spart_wrt_data,
   output logic        txd,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic [7:0]  ovf_cnt
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLK_DIV);

   logic         hit, is_push, is_clr, accept, drop;
   logic [3:0]   off;
   spart_entry_t din, head;
   logic         pop, empty, full;
   logic [AW:0]  count;

   tx_state_t    state, state_nx;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
   logic [2:0]   bit_idx, bit_idx_nx;
   logic [31:0]  shreg, shreg_nx;
   logic [2:0]   bytes_left, bytes_left_nx;
   logic [7:0]   cur_byte;
   logic         bit_end, txd_nx;

   // Address decode; no back-pressure, so a full FIFO drops unless popping now.
   assign off     = spart_wrt_add[3:0];
   assign hit     = spart_wrt_en && (spart_wrt_add[31:4] == WIN_BASE[31:4]);
   assign is_push = hit && ((off == SPART_OFF_BYTE) || (off == SPART_OFF_WORD));
   assign is_clr  = hit && (off == SPART_OFF_CLR);
   assign accept  = is_push && (!full || pop);
   assign drop    = is_push && !accept;

   assign din.data = (off == SPART_OFF_WORD) ? spart_wrt_data : {24'h0, spart_wrt_data[7:0]};
   assign din.len  = (off == SPART_OFF_WORD) ? SPART_LEN_WORD : SPART_LEN_BYTE;

   spart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_cnt <= '0;
      end else if (is_clr) begin
         ovf_cnt <= '0;
      end else if (drop && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   assign bit_end = (bit_cnt == CNT_W'(CLK_DIV - 1));

   always_comb begin
      state_nx      = state;
      bit_cnt_nx    = bit_cnt;
      bit_idx_nx    = bit_idx;
      shreg_nx      = shreg;
      bytes_left_nx = bytes_left;
      pop           = 1'b0;
      if (state != ST_IDLE) bit_cnt_nx = bit_end ? '0 : bit_cnt + CNT_W'(1);
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop           = 1'b1;
               shreg_nx      = head.data;
               bytes_left_nx = {1'b0, head.len} + 3'd1;
               bit_cnt_nx    = '0;
               state_nx      = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               bit_idx_nx = 3'd0;
               state_nx   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef SPART_PARITY_EN
                  state_nx = ST_PAR;
`else
                  state_nx = ST_STOP;
`endif
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end
         end
`ifdef SPART_PARITY_EN
         ST_PAR: begin
            if (bit_end) state_nx = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               // Remaining bytes of a WORD follow with no idle gap.
               if (bytes_left > 3'd1) begin
                  bytes_left_nx = bytes_left - 3'd1;
                  shreg_nx      = shreg >> 8;
                  state_nx      = ST_START;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      // txd is registered, so it is derived from the next-state values.
      cur_byte = shreg_nx[7:0];
      case (state_nx)
         ST_START: txd_nx = 1'b0;
         ST_DATA:  txd_nx = cur_byte[bit_idx_nx];
`ifdef SPART_PARITY_EN
         ST_PAR:   txd_nx = ^cur_byte;
`endif
         default:  txd_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         bytes_left <= '0;
         txd        <= 1'b1;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         bit_idx    <= bit_idx_nx;
         shreg      <= shreg_nx;
         bytes_left <= bytes_left_nx;
         txd        <= txd_nx;
      end
   end

   assign tx_busy   = (state != ST_IDLE) || (count != '0);
   assign fifo_full = full;

endmodule

// File: tb/tb_spart_wr_sink.sv
// Bench for spart_wr_sink: cycle-level occupancy/overflow model plus a byte
// scoreboard drained by a UART line monitor.
module tb_spart_wr_sink;

   localparam int          DEPTH = 4;
   localparam int          DIV   = 4;
   localparam logic [31:0] WIN   = 32'hFFFF_FFF0;
`ifdef SPART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk, rst, en;
   logic [31:0] add, data;
   logic        txd, tx_busy, fifo_full;
   logic [7:0]  ovf_cnt;

   int checks = 0;
   int errors = 0;

   // Reference state
   int         m_q[$];
   logic [7:0] exp_q[$];
   int         m_busy = 0;
   int         m_ovf  = 0;
   int         epoch  = 0;
   bit         m_pop, m_push, m_acc, m_hit;
   int         r;

   spart_wr_sink #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV), .WIN_BASE(WIN)) dut (
      .clk            (clk),
      .rst            (rst),
      .spart_wrt_en   (en),
      .spart_wrt_add  (add),
      .spart_wrt_data (data),
      .txd            (txd),
      .tx_busy        (tx_busy),
      .fifo_full      (fifo_full),
      .ovf_cnt        (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: one entry occupies the transmitter for len*NB*DIV cycles after its pop.
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         m_q.delete();
         exp_q.delete();
         m_busy = 0;
         m_ovf  = 0;
         epoch++;
      end else begin
         m_hit  = en && (add[31:4] == WIN[31:4]);
         m_push = m_hit && (add[3:0] == 4'h0 || add[3:0] == 4'h1);
         m_pop  = (m_busy == 0) && (m_q.size() > 0);
         m_acc  = m_push && (m_q.size() < DEPTH || m_pop);
         if (m_pop) m_busy = m_q.pop_front() * NB * DIV;
         else if (m_busy > 0) m_busy--;
         if (m_acc) begin
            if (add[3:0] == 4'h0) begin
               m_q.push_back(1);
               exp_q.push_back(data[7:0]);
            end else begin
               m_q.push_back(4);
               for (int k = 0; k < 4; k++) exp_q.push_back(data[8*k +: 8]);
            end
         end else if (m_push) begin
            if (m_ovf < 255) m_ovf++;
         end
         if (m_hit && add[3:0] == 4'h2) m_ovf = 0;
      end
      #1;
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("fifo_full", fifo_full, m_q.size() == DEPTH);
      chk("tx_busy", tx_busy, (m_busy > 0) || (m_q.size() > 0));
   end

   // Line monitor: samples bit centres and checks against the byte scoreboard.
   initial begin : mon
      logic [7:0] b;
      logic       st, sp;
      int         ep;
`ifdef SPART_PARITY_EN
      logic       pb;
`endif
      forever begin
         @(negedge clk);
         if (rst && txd === 1'b0) begin
            ep = epoch;
            repeat (2) @(negedge clk);
            st = txd;
            for (int k = 0; k < 8; k++) begin
               repeat (DIV) @(negedge clk);
               b[k] = txd;
            end
`ifdef SPART_PARITY_EN
            repeat (DIV) @(negedge clk);
            pb = txd;
`endif
            repeat (DIV) @(negedge clk);
            sp = txd;
            if (ep == epoch && rst) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", {24'h0, b}, 32'hFFFF_FFFF);
               end else begin
                  chk("start_bit", st, 1'b0);
                  chk("rx_byte", b, exp_q[0]);
`ifdef SPART_PARITY_EN
                  chk("parity_bit", pb, ^exp_q[0]);
`endif
                  chk("stop_bit", sp, 1'b1);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Called at a negedge; the write is sampled on the following posedge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      en   = 1'b1;
      add  = a;
      data = d;
      @(negedge clk);
      en   = 1'b0;
   endtask

   // Checks txd falls one edge after the write, then measures the frame length.
   task automatic frame_len(input string name, input int exp);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      chk({name, "_start"}, txd, 1'b0);
      while (tx_busy === 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, n, exp);
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n;
      n = 0;
      while (tx_busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, tx_busy, 1'b0);
   endtask

   initial begin
      logic low_seen;
      rst  = 1'b0;
      en   = 1'b0;
      add  = '0;
      data = '0;
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_ovf", ovf_cnt, 8'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      wr(WIN | 32'h0, 32'h0000_0055);
      frame_len("byte55_len", NB * DIV);

      wr(WIN | 32'h1, 32'hA1B2_C3D4);
      frame_len("word_len", 4 * NB * DIV);

      // Out-of-window and unused offset
      wr(WIN + 32'h10, 32'h41);
      wr(WIN | 32'h5, 32'h42);
      low_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) low_seen = 1'b1;
      end
      chk("miss_txd_idle", low_seen, 1'b0);
      chk("miss_busy", tx_busy, 1'b0);
      chk("miss_ovf", ovf_cnt, 8'd0);

      // Six back-to-back bytes: one pops, four queue, one drops
      for (int i = 0; i < 6; i++) wr(WIN | 32'h0, 32'h30 + i);
      chk("burst_full", fifo_full, 1'b1);
      chk("burst_ovf", ovf_cnt, 8'd1);
      wr(WIN | 32'h2, 32'h0);
      chk("clr_ovf", ovf_cnt, 8'd0);
      chk("clr_keeps_fifo", tx_busy, 1'b1);
      wait_idle("burst", 2000);

      // Reset in the middle of a WORD frame
      wr(WIN | 32'h1, 32'h4400_0000);
      repeat (50) @(negedge clk);
      chk("pre_rst_txd_low", txd, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_mid_txd", txd, 1'b1);
      chk("rst_mid_busy", tx_busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (50) @(negedge clk);
      wr(WIN | 32'h0, 32'h0000_000F);
      frame_len("byte0f_len", NB * DIV);

`ifdef SPART_PARITY_EN
      wr(WIN | 32'h0, 32'h07);
      frame_len("par07_len", 11 * DIV);
      wr(WIN | 32'h0, 32'h03);
      frame_len("par03_len", 11 * DIV);
`endif

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         r    = $urandom_range(0, 9);
         data = $urandom;
         en   = 1'b1;
         case (r)
            0, 1, 2: add = WIN | 32'h0;
            3, 4:    add = WIN | 32'h1;
            5:       add = WIN | 32'h2;
            6:       add = WIN | 32'h5;
            7:       add = WIN ^ 32'h100;
            default: en = 1'b0;
         endcase
         @(negedge clk);
      end
      en = 1'b0;
      wait_idle("random", 5000);
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
